// File: rtl/alu_arbiter.sv
// Shares one registered 8-bit ALU between the execute stage (port 0) and the address/PC helper (port 1).
// Sequences each operation (latch, enable, capture) and returns result/flags over a valid/ready channel.
module alu_arbiter #(
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic       clk,
  input  logic       rst,

  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [2:0] req0_mode,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,

  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [2:0] req1_mode,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,

  output logic       rsp0_valid,
  input  logic       rsp0_ready,
  output logic [7:0] rsp0_data,
  output logic       rsp0_zero,
  output logic       rsp0_carry,
  output logic       rsp0_err,

  output logic       rsp1_valid,
  input  logic       rsp1_ready,
  output logic [7:0] rsp1_data,
  output logic       rsp1_zero,
  output logic       rsp1_carry,
  output logic       rsp1_err,

  output logic       alu_enable,
  output logic [2:0] alu_mode,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_out,
  input  logic       alu_zero,
  input  logic       alu_carry
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_next_state;

  logic       r_last_grant;
  logic       r_owner;
  logic [2:0] r_mode;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [7:0] r_data;
  logic       r_zero;
  logic       r_carry;
  logic       r_err;

  logic       w_grant;
  logic       w_accept;
  logic [2:0] w_grant_mode;
  logic [7:0] w_grant_a;
  logic [7:0] w_grant_b;
  logic       w_grant_legal;
  logic       w_is_arith;
  logic       w_rsp_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    w_grant = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant = PRIO_FIXED ? 1'b0 : ~r_last_grant;
    end else if (req1_valid) begin
      w_grant = 1'b1;
    end
  end

  assign w_accept     = (r_state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready   = w_accept && !w_grant;
  assign req1_ready   = w_accept &&  w_grant;

  assign w_grant_mode = w_grant ? req1_mode : req0_mode;
  assign w_grant_a    = w_grant ? req1_a    : req0_a;
  assign w_grant_b    = w_grant ? req1_b    : req0_b;

  assign w_grant_legal = (w_grant_mode == OP_ADD) || (w_grant_mode == OP_SUB) ||
                         (w_grant_mode == OP_AND) || (w_grant_mode == OP_OR);

  // The ALU leaves its carry untouched on logic ops, so only arithmetic ops may forward it.
  assign w_is_arith  = (r_mode == OP_ADD) || (r_mode == OP_SUB);
  assign w_rsp_ready = r_owner ? rsp1_ready : rsp0_ready;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = w_grant_legal ? ISSUE : RESP;
      ISSUE:   w_next_state = WAIT;
      WAIT:    w_next_state = RESP;
      RESP:    if (w_rsp_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: flops use non-blocking assignments so every register samples pre-edge values regardless of block order.
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_mode       <= 3'b000;
      r_a          <= 8'h00;
      r_b          <= 8'h00;
      r_data       <= 8'h00;
      r_zero       <= 1'b0;
      r_carry      <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      if (w_accept) begin
        r_owner      <= w_grant;
        r_last_grant <= w_grant;
        r_mode       <= w_grant_mode;
        r_a          <= w_grant_a;
        r_b          <= w_grant_b;
        if (!w_grant_legal) begin
          r_data  <= 8'h00;
          r_zero  <= 1'b0;
          r_carry <= 1'b0;
          r_err   <= 1'b1;
        end
      end
      if (r_state == WAIT) begin
        r_data  <= alu_out;
        r_zero  <= alu_zero;
        r_carry <= w_is_arith ? alu_carry : 1'b0;
        r_err   <= 1'b0;
      end
    end
  end

  assign alu_enable = (r_state == ISSUE);
  assign alu_mode   = r_mode;
  assign alu_a      = r_a;
  assign alu_b      = r_b;

  assign rsp0_valid = (r_state == RESP) && !r_owner;
  assign rsp1_valid = (r_state == RESP) &&  r_owner;

  assign rsp0_data  = r_data;
  assign rsp0_zero  = r_zero;
  assign rsp0_carry = r_carry;
  assign rsp0_err   = r_err;
  assign rsp1_data  = r_data;
  assign rsp1_zero  = r_zero;
  assign rsp1_carry = r_carry;
  assign rsp1_err   = r_err;

  a_single_owner: assert property (@(posedge clk) disable iff (rst) !(rsp0_valid && rsp1_valid));
  a_enable_pulse: assert property (@(posedge clk) disable iff (rst) alu_enable |=> !alu_enable);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: instance 0 is round-robin, instance 1 is fixed-priority,
// each paired with a behavioural registered ALU that keeps a stale carry on logic ops.
module tb_alu_arbiter;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_BAD = 3'b111;

  typedef struct packed {
    logic [7:0] data;
    logic       zero;
    logic       carry;
    logic       err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       req_valid [2][2];
  logic       req_ready [2][2];
  logic [2:0] req_mode  [2][2];
  logic [7:0] req_a     [2][2];
  logic [7:0] req_b     [2][2];
  logic       rsp_valid [2][2];
  logic       rsp_ready [2][2];
  logic [7:0] rsp_data  [2][2];
  logic       rsp_zero  [2][2];
  logic       rsp_carry [2][2];
  logic       rsp_err   [2][2];
  logic       alu_enable [2];
  logic [2:0] alu_mode   [2];
  logic [7:0] alu_a      [2];
  logic [7:0] alu_b      [2];

  rsp_t  exp_q [4][$];
  int    acc_q [4][$];
  int    rep   [2][2];
  int    grant_log [$];
  int    grant_cyc [$];
  int    en_cnt;
  logic [18:0] last_issue;
  int    n_checks = 0;
  int    n_pass   = 0;

  function automatic logic [9:0] alu_calc(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b,
                                          input logic c_old);
    logic [8:0] s;
    logic       c;
    s = 9'h000;
    c = c_old;
    case (m)
      OP_ADD: begin s = {1'b0, a} + {1'b0, b}; c = s[8]; end
      OP_SUB: begin s = {1'b0, a} - {1'b0, b}; c = (a < b); end
      OP_AND: s = {1'b0, a & b};
      OP_OR:  s = {1'b0, a | b};
      default: s = 9'h000;
    endcase
    return {c, (s[7:0] == 8'h00), s[7:0]};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [7:0] alu_out_q;
    logic       alu_zero_q;
    logic       alu_carry_q;

    always @(posedge clk) begin
      if (alu_enable[g]) begin
        {alu_carry_q, alu_zero_q, alu_out_q} <= alu_calc(alu_mode[g], alu_a[g], alu_b[g], alu_carry_q);
      end
    end

    alu_arbiter #(.PRIO_FIXED(g)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req_valid[g][0]),
      .req0_ready (req_ready[g][0]),
      .req0_mode  (req_mode[g][0]),
      .req0_a     (req_a[g][0]),
      .req0_b     (req_b[g][0]),
      .req1_valid (req_valid[g][1]),
      .req1_ready (req_ready[g][1]),
      .req1_mode  (req_mode[g][1]),
      .req1_a     (req_a[g][1]),
      .req1_b     (req_b[g][1]),
      .rsp0_valid (rsp_valid[g][0]),
      .rsp0_ready (rsp_ready[g][0]),
      .rsp0_data  (rsp_data[g][0]),
      .rsp0_zero  (rsp_zero[g][0]),
      .rsp0_carry (rsp_carry[g][0]),
      .rsp0_err   (rsp_err[g][0]),
      .rsp1_valid (rsp_valid[g][1]),
      .rsp1_ready (rsp_ready[g][1]),
      .rsp1_data  (rsp_data[g][1]),
      .rsp1_zero  (rsp_zero[g][1]),
      .rsp1_carry (rsp_carry[g][1]),
      .rsp1_err   (rsp_err[g][1]),
      .alu_enable (alu_enable[g]),
      .alu_mode   (alu_mode[g]),
      .alu_a      (alu_a[g]),
      .alu_b      (alu_b[g]),
      .alu_out    (alu_out_q),
      .alu_zero   (alu_zero_q),
      .alu_carry  (alu_carry_q)
    );
  end

  // Reference result, written from the arithmetic definition rather than from the ALU model.
  function automatic rsp_t exp_of(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b);
    rsp_t r;
    int   ia;
    int   ib;
    int   res;
    r  = '0;
    ia = int'(a);
    ib = int'(b);
    case (m)
      OP_ADD: begin res = ia + ib; r.carry = (res > 255); end
      OP_SUB: begin res = ia - ib; r.carry = (ia < ib); end
      OP_AND: res = int'(a & b);
      OP_OR:  res = int'(a | b);
      default: begin res = 0; r.err = 1'b1; end
    endcase
    r.data = res[7:0];
    r.zero = !r.err && (r.data == 8'h00);
    return r;
  endfunction

  task automatic post(input int k, input int n, input logic [2:0] m, input logic [7:0] a, input logic [7:0] b,
                      input int reps);
    req_mode[k][n]  = m;
    req_a[k][n]     = a;
    req_b[k][n]     = b;
    req_valid[k][n] = 1'b1;
    rep[k][n]       = reps;
    for (int i = 0; i < reps; i++) exp_q[k*2+n].push_back(exp_of(m, a, b));
  endtask

  // Called at a falling edge; services instance k until all posted requests have been answered.
  task automatic run(input int k, input int budget);
    bit drop [2];
    bit both;
    bit done;
    drop = '{1'b0, 1'b0};
    both = 1'b0;
    done = 1'b0;
    grant_log.delete();
    grant_cyc.delete();
    en_cnt = 0;
    rsp_ready[k][0] = 1'b1;
    rsp_ready[k][1] = 1'b1;
    for (int cyc = 0; cyc < budget && !done; cyc++) begin
      #1;
      if (alu_enable[k]) begin
        en_cnt++;
        last_issue = {alu_mode[k], alu_a[k], alu_b[k]};
      end
      if (rsp_valid[k][0] && rsp_valid[k][1]) both = 1'b1;
      for (int n = 0; n < 2; n++) begin
        rsp_t obs;
        rsp_t exp_r;
        int   lat;
        if (req_valid[k][n] && req_ready[k][n]) begin
          grant_log.push_back(n);
          grant_cyc.push_back(cyc);
          acc_q[k*2+n].push_back(cyc);
          rep[k][n]--;
          if (rep[k][n] == 0) drop[n] = 1'b1;
        end
        if (rsp_valid[k][n]) begin
          obs = {rsp_data[k][n], rsp_zero[k][n], rsp_carry[k][n], rsp_err[k][n]};
          n_checks++;
          if (exp_q[k*2+n].size() == 0 || acc_q[k*2+n].size() == 0) begin
            $display("FAIL unexpected_rsp inst%0d port%0d: got data=%h with nothing outstanding", k, n, obs.data);
          end else begin
            exp_r = exp_q[k*2+n].pop_front();
            lat   = cyc - acc_q[k*2+n].pop_front();
            if (obs !== exp_r) begin
              $display("FAIL rsp_data inst%0d port%0d: got data=%h z=%b c=%b e=%b, want data=%h z=%b c=%b e=%b",
                       k, n, obs.data, obs.zero, obs.carry, obs.err, exp_r.data, exp_r.zero, exp_r.carry, exp_r.err);
            end else begin
              n_pass++;
            end
            n_checks++;
            if (lat != (exp_r.err ? 1 : 3)) begin
              $display("FAIL rsp_latency inst%0d port%0d: got %0d cycles, want %0d", k, n, lat, exp_r.err ? 1 : 3);
            end else begin
              n_pass++;
            end
          end
        end
      end
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
        if (drop[n]) begin
          req_valid[k][n] = 1'b0;
          drop[n] = 1'b0;
        end
      end
      done = (rep[k][0] == 0) && (rep[k][1] == 0) && (exp_q[k*2].size() == 0) && (exp_q[k*2+1].size() == 0);
    end
    n_checks++;
    if (!done) $display("FAIL run_timeout inst%0d: requests still outstanding after %0d cycles", k, budget);
    else n_pass++;
    n_checks++;
    if (both) $display("FAIL dual_rsp inst%0d: rsp0_valid and rsp1_valid seen together", k);
    else n_pass++;
  endtask

  task automatic test_reset();
    logic [4:0]  ctrl;
    logic [40:0] dat;
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 2; n++) begin
        req_valid[k][n] = 1'b0;
        req_mode[k][n]  = 3'b000;
        req_a[k][n]     = 8'h00;
        req_b[k][n]     = 8'h00;
        rsp_ready[k][n] = 1'b0;
        rep[k][n]       = 0;
      end
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      ctrl = {req_ready[k][0], req_ready[k][1], rsp_valid[k][0], rsp_valid[k][1], alu_enable[k]};
      dat  = {alu_mode[k], alu_a[k], alu_b[k],
              rsp_data[k][0], rsp_zero[k][0], rsp_carry[k][0], rsp_err[k][0],
              rsp_data[k][1], rsp_zero[k][1], rsp_carry[k][1], rsp_err[k][1]};
      n_checks++;
      if (ctrl !== 5'b0) $display("FAIL reset_ctrl inst%0d: got %b, want 00000", k, ctrl);
      else n_pass++;
      n_checks++;
      if (dat !== 41'b0) $display("FAIL reset_data inst%0d: got %h, want 0", k, dat);
      else n_pass++;
    end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    bit order_ok;
    bit space_ok;
    post(0, 0, OP_SUB, 8'h05, 8'h05, 4);
    post(0, 1, OP_OR,  8'h0F, 8'hF0, 4);
    run(0, 100);
    order_ok = (grant_log.size() == 8);
    space_ok = (grant_cyc.size() == 8);
    for (int i = 0; i < grant_log.size(); i++) if (grant_log[i] != (i % 2)) order_ok = 1'b0;
    for (int i = 1; i < grant_cyc.size(); i++) if (grant_cyc[i] - grant_cyc[i-1] != 4) space_ok = 1'b0;
    n_checks++;
    if (!order_ok) $display("FAIL rr_grant_order: got %p, want 0,1,0,1,0,1,0,1", grant_log);
    else n_pass++;
    n_checks++;
    if (!space_ok) $display("FAIL rr_throughput: accept cycles %p, want spacing of 4", grant_cyc);
    else n_pass++;
  endtask

  task automatic test_single();
    post(0, 0, OP_ADD, 8'hF0, 8'h20, 1);
    run(0, 50);
    n_checks++;
    if (grant_log.size() != 1 || grant_log[0] != 0) $display("FAIL single_grant: got %p, want 0", grant_log);
    else n_pass++;
    n_checks++;
    if (en_cnt != 1) $display("FAIL single_enable: alu_enable high %0d cycles, want 1", en_cnt);
    else n_pass++;
    n_checks++;
    if (last_issue !== {OP_ADD, 8'hF0, 8'h20}) $display("FAIL single_operands: got %h, want %h", last_issue, {OP_ADD, 8'hF0, 8'h20});
    else n_pass++;
  endtask

  task automatic test_fixed_priority();
    bit ok;
    post(1, 0, OP_ADD, 8'h10, 8'h20, 4);
    post(1, 1, OP_SUB, 8'h03, 8'h05, 1);
    run(1, 100);
    ok = (grant_log.size() == 5);
    for (int i = 0; i < grant_log.size(); i++) if (grant_log[i] != ((i == 4) ? 1 : 0)) ok = 1'b0;
    n_checks++;
    if (!ok) $display("FAIL fixed_starve: got %p, want 0,0,0,0,1", grant_log);
    else n_pass++;
  endtask

  task automatic test_stale_carry();
    post(0, 0, OP_ADD, 8'hFF, 8'h01, 1);
    run(0, 50);
    post(0, 0, OP_AND, 8'hFF, 8'h00, 1);
    run(0, 50);
  endtask

  task automatic test_illegal_hold();
    rsp_t obs;
    rsp_t first;
    rsp_t exp_r;
    bit   hold_ok;
    bit   en_seen;
    rsp_ready[0][0] = 1'b0;
    rsp_ready[0][1] = 1'b0;
    post(0, 1, OP_BAD, 8'h12, 8'h34, 1);
    #1;
    n_checks++;
    if (req_ready[0][1] !== 1'b1 || req_ready[0][0] !== 1'b0)
      $display("FAIL illegal_accept: got ready0=%b ready1=%b, want 0 1", req_ready[0][0], req_ready[0][1]);
    else n_pass++;
    @(negedge clk);
    req_valid[0][1] = 1'b0;
    rep[0][1] = 0;
    post(0, 0, OP_ADD, 8'h01, 8'h01, 1);
    #1;
    first = {rsp_data[0][1], rsp_zero[0][1], rsp_carry[0][1], rsp_err[0][1]};
    exp_r = exp_q[1].pop_front();
    n_checks++;
    if (rsp_valid[0][1] !== 1'b1 || first !== exp_r)
      $display("FAIL illegal_rsp: got valid=%b data=%h err=%b, want valid=1 data=%h err=%b",
               rsp_valid[0][1], first.data, first.err, exp_r.data, exp_r.err);
    else n_pass++;
    hold_ok = 1'b1;
    en_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      obs = {rsp_data[0][1], rsp_zero[0][1], rsp_carry[0][1], rsp_err[0][1]};
      if (rsp_valid[0][1] !== 1'b1 || rsp_valid[0][0] !== 1'b0 || obs !== first || req_ready[0][0] !== 1'b0)
        hold_ok = 1'b0;
      if (alu_enable[0] !== 1'b0) en_seen = 1'b1;
    end
    n_checks++;
    if (!hold_ok) $display("FAIL illegal_hold: response not held stable or port 0 accepted while rsp1_ready low");
    else n_pass++;
    n_checks++;
    if (en_seen) $display("FAIL illegal_enable: alu_enable went high for an illegal opcode");
    else n_pass++;
    @(negedge clk);
    rsp_ready[0][1] = 1'b1;
    #1;
    n_checks++;
    if (req_ready[0][0] !== 1'b0 || rsp_valid[0][1] !== 1'b1)
      $display("FAIL handshake_no_accept: got ready0=%b rsp1_valid=%b, want 0 1", req_ready[0][0], rsp_valid[0][1]);
    else n_pass++;
    @(negedge clk);
    rsp_ready[0][1] = 1'b0;
    run(0, 50);
    n_checks++;
    if (grant_cyc.size() != 1 || grant_cyc[0] != 0)
      $display("FAIL pending_accept: accept cycles %p, want 0", grant_cyc);
    else n_pass++;
  endtask

  task automatic test_reset_midop();
    bit   quiet;
    logic [23:0] st;
    post(0, 0, OP_ADD, 8'h33, 8'h44, 1);
    #1;
    n_checks++;
    if (req_ready[0][0] !== 1'b1) $display("FAIL midop_accept: got ready0=%b, want 1", req_ready[0][0]);
    else n_pass++;
    @(negedge clk);
    req_valid[0][0] = 1'b0;
    rep[0][0] = 0;
    #1;
    n_checks++;
    if (alu_enable[0] !== 1'b1) $display("FAIL midop_issue: got alu_enable=%b, want 1", alu_enable[0]);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q[0].delete();
    #1;
    st = {rsp_valid[0][0], rsp_valid[0][1], alu_enable[0], req_ready[0][0], req_ready[0][1], alu_mode[0], alu_a[0], alu_b[0]};
    n_checks++;
    if (st !== 24'h0) $display("FAIL midop_reset: got %h, want 000000", st);
    else n_pass++;
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (rsp_valid[0][0] !== 1'b0 || rsp_valid[0][1] !== 1'b0 || alu_enable[0] !== 1'b0) quiet = 1'b0;
    end
    n_checks++;
    if (!quiet) $display("FAIL midop_discard: response or enable appeared after reset");
    else n_pass++;
    @(negedge clk);
    post(0, 0, OP_OR,  8'h0F, 8'h30, 1);
    post(0, 1, OP_ADD, 8'h02, 8'h03, 1);
    run(0, 50);
    n_checks++;
    if (grant_log.size() != 2 || grant_log[0] != 0 || grant_cyc[0] != 0)
      $display("FAIL midop_after: got grants %p at %p, want 0,1 starting at cycle 0", grant_log, grant_cyc);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_fixed_priority();
    test_stale_carry();
    test_illegal_hold();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 8-bit ALU between two requesters: port 0 is the execute stage, port 1 is the address/PC helper.
- Arbitrates between them, then sequences the ALU's registered one-cycle operation: latch operands, pulse enable, capture result and flags.
- Returns the result to the winning requester over a valid/ready response channel.
- Sits between the control unit and the ALU; the only module that drives the ALU's enable/mode/operand inputs.

Parameters:
- PRIO_FIXED, 0. 0 = round-robin between ports; 1 = port 0 always wins simultaneous requests.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- reqN_valid  input  1  request from port N (N=0,1)
- reqN_ready  output  1  request accepted this cycle
- reqN_mode  input  3  ALU opcode (`OP_ADD/`OP_SUB/`OP_AND/`OP_OR from parameters.v)
- reqN_a, reqN_b  input  8  operands
- rspN_valid  output  1  response available for port N
- rspN_ready  input  1  port N consumes response
- rspN_data  output  8  ALU result
- rspN_zero, rspN_carry, rspN_err  output  1  zero flag, carry/borrow flag, illegal-opcode flag
- alu_enable  output  1  ALU enable
- alu_mode  output  3  ALU mode
- alu_a, alu_b  output  8  ALU operands
- alu_out  input  8  ALU result (registered in ALU)
- alu_zero, alu_carry  input  1  ALU flags

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high.
- Reset values:
  - state=IDLE.
  - All reqN_ready, rspN_valid, alu_enable are 0.
  - rsp data/flags are 0.
  - alu_mode/a/b are 0.
  - last_grant=1, so port 0 wins the first contention.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant rules:
    - If exactly one reqN_valid, grant N.
    - If both are valid and PRIO_FIXED=0, grant the port != last_grant.
    - If both are valid and PRIO_FIXED=1, grant 0.
  - reqN_ready=1 combinationally for the granted port only, and only in IDLE.
  - On that edge: latch mode/a/b and owner; update last_grant.
  - Next state is ISSUE if mode is legal, else RESP with data=8'h00, zero=0, carry=0, err=1. The ALU is never enabled for an illegal mode.
- ISSUE (1 cycle): alu_enable=1, alu_mode/a/b driven from the latched registers. The ALU computes at the edge ending this cycle. Next state is WAIT.
- WAIT (1 cycle):
  - alu_enable=0; operand outputs are held.
  - Capture alu_out→data and alu_zero→zero.
  - Capture carry=alu_carry for ADD/SUB; carry=0 for AND/OR, because the ALU's carry is stale on logic ops.
  - err=0. Next state is RESP.
- RESP:
  - rsp{owner}_valid=1, with data/flags stable, until rsp{owner}_ready=1.
  - On the handshake edge, return to IDLE.
  - New arbitration starts the cycle after. No accept occurs in the same cycle as the response handshake.
- Latency and throughput:
  - Accept edge to rsp_valid: 3 cycles for a legal op, 1 cycle for an illegal op.
  - Maximum throughput is one op per 4 cycles when responses are accepted immediately.
- Requester obligations:
  - Hold mode/a/b stable while valid && !ready.
  - Requests arriving while busy stay pending. They are not dropped.
- rspN_ready for the non-owner port, or while not in RESP, is ignored.
- Arithmetic rules:
  - SUB carry = borrow, matching the ALU: in_a < in_b gives carry=1.
  - zero is the ALU's flag computed on the 8-bit result.
- Reset mid-operation: the next edge with rst=1 forces IDLE. The in-flight op is discarded with no response, and alu_enable drops. The ALU's stale output is never forwarded.
- Only one op is ever in flight. rsp0_valid and rsp1_valid are never both 1.

Test Plan:
- Port 0 only, ADD a=8'hF0 b=8'h20 -> req0_ready pulse, alu_enable for exactly 1 cycle, 3 cycles later rsp0_valid with data=8'h10, carry=1, zero=0, err=0.
- Both ports valid in the same cycle, repeatedly (port 0 SUB 5-5, port 1 OR 0x0F|0xF0), PRIO_FIXED=0 -> grants alternate 0,1,0,1. Port 0 gets data=0, zero=1, carry=0; port 1 gets data=8'hFF, zero=0.
- PRIO_FIXED=1 with port 0 continuously valid -> port 1 starves, never granted while port 0 is valid. Port 1 is granted once port 0 deasserts.
- ADD 0xFF+0x01 (carry=1), then AND 0xFF&0x00 -> AND response has carry=0, zero=1.
- Port 1 mode=3'b111 -> no alu_enable; rsp1_valid 1 cycle after accept with err=1, data=0. rsp1_ready held low for 5 cycles -> response held stable, port 0 request stays pending, no ready.
- Assert rst during WAIT -> next cycle state is IDLE, no rsp valid, alu_enable=0. A following request completes normally, with last_grant reset so port 0 wins contention.
